// File: rtl/shift_operand_pipe.sv
// Two-stage elastic operand-2 generator: decode/resolve stage, then shifter into the output register.
// Optional carry path enabled by defining SHIFT_OPERAND_CARRY_EN; otherwise o_Carry_Out is tied low.
module shift_operand_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [DATA_WIDTH-1:0] i_Rm,
  input  logic [DATA_WIDTH-1:0] i_Rs,
  input  logic [11:0]           i_Shift_Operand,
  input  logic                  i_Immediate,
  input  logic                  i_Sig_Memory_Instruction,
  input  logic                  i_Reg_Shift,
  input  logic                  i_Carry_In,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic                  o_Carry_Out
);

  localparam int W  = DATA_WIDTH;
  localparam int LW = $clog2(W);
  localparam logic [7:0] AMT_W = 8'(W);

  typedef enum logic [1:0] {K_MEM, K_RRX, K_SHF} kind_e;
  typedef enum logic [1:0] {T_LSL, T_LSR, T_ASR, T_ROR} shift_e;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] m);
    return W'({x, x} >> m);
  endfunction

  // Every form is reduced to a register-style shift with an 8-bit amount, except RRX.
  function automatic logic [W:0] shift_eval(input kind_e kind, input shift_e typ,
                                            input logic [7:0] amt, input logic [W-1:0] x,
                                            input logic cin);
    logic [W-1:0]        res;
    logic [W-1:0]        tl;
    logic [W-1:0]        tr;
    logic signed [W-1:0] xs;
    logic                c;
    res = x;
    c   = cin;
    xs  = x;
    tl  = x << (amt - 8'd1);
    tr  = x >> (amt - 8'd1);
    case (kind)
      K_MEM: c = cin;
      K_RRX: begin
        res = {cin, x[W-1:1]};
        c   = x[0];
      end
      default: begin
        if (amt != 8'd0) begin
          case (typ)
            T_LSL: begin
              res = (amt >= AMT_W) ? '0 : (x << amt);
              c   = (amt > AMT_W) ? 1'b0 : tl[W-1];
            end
            T_LSR: begin
              res = (amt >= AMT_W) ? '0 : (x >> amt);
              c   = (amt > AMT_W) ? 1'b0 : tr[0];
            end
            T_ASR: begin
              if (amt >= AMT_W) begin
                res = {W{x[W-1]}};
                c   = x[W-1];
              end else begin
                res = xs >>> amt;
                c   = tr[0];
              end
            end
            default: begin
              res = rotr(x, amt[LW-1:0]);
              c   = res[W-1];
            end
          endcase
        end
      end
    endcase
    return {c, res};
  endfunction

  logic          r_vld_p1;
  kind_e         r_kind_p1;
  shift_e        r_type_p1;
  logic [7:0]    r_amt_p1;
  logic [W-1:0]  r_opnd_p1;
  logic          r_cin_p1;
  logic          r_vld_p2;
  logic [W-1:0]  r_res_p2;

  kind_e         w_kind;
  shift_e        w_type;
  logic [7:0]    w_amt;
  logic [W-1:0]  w_opnd;
  logic [W:0]    w_eval;
  logic          w_load_p2;
  logic          w_adv_p1;
  logic          w_accept;
  logic          w_unused_rs;

  assign w_unused_rs = ^i_Rs[W-1:8];

  assign w_load_p2 = !r_vld_p2 || i_Ready;
  assign w_adv_p1  = r_vld_p1 && w_load_p2;
  assign o_Ready   = !r_vld_p1 || w_adv_p1;
  assign w_accept  = i_Valid && o_Ready;

  always_comb begin
    w_kind = K_SHF;
    w_type = shift_e'(i_Shift_Operand[6:5]);
    w_amt  = 8'd0;
    w_opnd = i_Rm;
    if (i_Sig_Memory_Instruction) begin
      w_kind = K_MEM;
      w_opnd = {{(W-12){i_Shift_Operand[11]}}, i_Shift_Operand};
    end else if (i_Immediate) begin
      w_type = T_ROR;
      w_amt  = {3'b000, i_Shift_Operand[11:8], 1'b0};
      w_opnd = {{(W-8){1'b0}}, i_Shift_Operand[7:0]};
    end else if (i_Reg_Shift) begin
      w_amt = i_Rs[7:0];
    end else begin
      w_amt = {3'b000, i_Shift_Operand[11:7]};
      // A zero immediate amount encodes shift-by-W for LSR/ASR and RRX for ROR.
      if (i_Shift_Operand[11:7] == 5'd0) begin
        case (w_type)
          T_LSR, T_ASR: w_amt = AMT_W;
          T_ROR:        w_kind = K_RRX;
          default:      w_amt = 8'd0;
        endcase
      end
    end
  end

  // Stage 1: decoded request
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
    end else if (w_adv_p1) begin
      r_vld_p1 <= 1'b0;
    end
    if (w_accept) begin
      r_kind_p1 <= w_kind;
      r_type_p1 <= w_type;
      r_amt_p1  <= w_amt;
      r_opnd_p1 <= w_opnd;
      r_cin_p1  <= i_Carry_In;
    end
  end

  assign w_eval = shift_eval(r_kind_p1, r_type_p1, r_amt_p1, r_opnd_p1, r_cin_p1);

  // Stage 2: shifter output register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_vld_p2 <= 1'b0;
      r_res_p2 <= '0;
    end else if (w_load_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_res_p2 <= w_eval[W-1:0];
    end
  end

`ifdef SHIFT_OPERAND_CARRY_EN
  logic r_carry_p2;
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_carry_p2 <= 1'b0;
    end else if (w_load_p2 && r_vld_p1) begin
      r_carry_p2 <= w_eval[W];
    end
  end
  assign o_Carry_Out = r_carry_p2;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_eval[W];
  assign o_Carry_Out    = 1'b0;
`endif

  assign o_Valid  = r_vld_p2;
  assign o_Result = r_res_p2;

endmodule
